// File: rtl/vec_mem_seq_if.sv
// Bus bundle between the vector memory stage, the sequencer and the scalar dmem port.
// slave = sequencer side, master = pipeline/memory side.
interface vec_mem_seq_if #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16
);
    localparam int VEC_W = LANES * LANE_W;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [VEC_W-1:0]  req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [VEC_W-1:0]  resp_rdata;
    logic              busy;
    logic [31:0]       mem_addr;
    logic              mem_w_enable;
    logic              mem_src_sel;
    logic [LANE_W-1:0] mem_w_data;
    logic [LANE_W-1:0] mem_q;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_q,
        output req_ready, resp_valid, resp_rdata, busy,
               mem_addr, mem_w_enable, mem_src_sel, mem_w_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_q,
        input  req_ready, resp_valid, resp_rdata, busy,
               mem_addr, mem_w_enable, mem_src_sel, mem_w_data
    );
endinterface

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: splits one 256-bit request into 16 halfword
// accesses on the scalar dmem port and gathers load data back into one vector.
//
// state | meaning
// IDLE  | ready for a request
// WRITE | issuing one store lane per cycle
// READ  | issuing one load address per cycle
// DRAIN | waiting RD_LAT cycles for the last load data
// DONE  | response valid, waiting for resp_ready
module vec_mem_seq #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int RD_LAT = 1
) (
    input logic         clk,
    input logic         rst_n,
    vec_mem_seq_if.slave bus
);
    localparam int VEC_W = LANES * LANE_W;
    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       base_q;
    logic [VEC_W-1:0]  wdata_q;
    logic [IDX_W-1:0]  lane_q;
    logic [1:0]        drain_cnt;
    logic [VEC_W-1:0]  rdata_q;
    logic              cap_vld [RD_LAT];
    logic [IDX_W-1:0]  cap_idx [RD_LAT];

    logic accept;
    logic last_lane;
    logic drain_done;

    assign accept     = (state == IDLE) && bus.req_valid;
    assign last_lane  = (lane_q == IDX_W'(LANES - 1));
    assign drain_done = (drain_cnt == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = bus.req_we ? WRITE : READ;
            WRITE:   if (last_lane) state_nxt = DONE;
            READ:    if (last_lane) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = DONE;
            DONE:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            wdata_q   <= '0;
            lane_q    <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept) begin
                base_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                lane_q  <= '0;
            end else if (state == WRITE || state == READ) begin
                lane_q <= lane_q + 1'b1;
            end
            // Down-counter for the read latency tail; DRAIN exits at terminal count 0.
            if (state == READ && last_lane)
                drain_cnt <= 2'(RD_LAT - 1);
            else if (state == DRAIN && !drain_done)
                drain_cnt <= drain_cnt - 2'd1;
        end
    end

    // Lane tags travel alongside the RAM read latency so each returning halfword
    // lands in the lane whose address produced it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                cap_vld[i] <= 1'b0;
                cap_idx[i] <= '0;
            end
        end else begin
            cap_vld[0] <= (state == READ);
            cap_idx[0] <= lane_q;
            for (int i = 1; i < RD_LAT; i++) begin
                cap_vld[i] <= cap_vld[i-1];
                cap_idx[i] <= cap_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata_q <= '0;
        else if (accept)
            rdata_q <= '0;
        else if (cap_vld[RD_LAT-1])
            rdata_q[cap_idx[RD_LAT-1]*LANE_W +: LANE_W] <= bus.mem_q;
    end

    assign bus.req_ready    = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.resp_valid   = (state == DONE);
    assign bus.resp_rdata   = rdata_q;
    assign bus.mem_src_sel  = 1'b0;
    assign bus.mem_w_enable = (state == WRITE);
    assign bus.mem_addr     = (state == WRITE || state == READ) ? base_q + 32'(lane_q) : 32'd0;
    assign bus.mem_w_data   = (state == WRITE) ? wdata_q[lane_q*LANE_W +: LANE_W] : '0;
endmodule

// File: doc/vec_mem_seq.md
# vec_mem_seq

Vector load/store sequencer for the data memory. It accepts one 256-bit vector load or store request and splits it into 16 consecutive 16-bit accesses on the scalar (port A) side of `dmem`. For loads, it gathers the returned halfwords back into one 256-bit response. It sits between the vector pipeline's memory stage and `dmem`, so vector traffic can run while only the scalar RAM port is instantiated.

## Interface
Parameters:
- `LANES`, 16: halfword lanes per vector.
- `LANE_W`, 16: bits per lane; vector width = `LANES*LANE_W` = 256.
- `RD_LAT`, 1: cycles from the address cycle to valid `mem_q` (registered-address RAM). Legal range 1..3.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: sequencer can accept a request.
- `req_we` input 1: 1 = vector store, 0 = vector load.
- `req_addr` input 32: base halfword address of lane 0.
- `req_wdata` input 256: store data; lane i = bits [16i+15:16i].
- `resp_valid` output 1: operation complete; load data valid.
- `resp_ready` input 1: consumer takes the response.
- `resp_rdata` output 256: gathered load data; lane i = bits [16i+15:16i].
- `busy` output 1: high in every state except IDLE.
- `mem_addr` output 32: to `dmem.addr`.
- `mem_w_enable` output 1: to `dmem.w_enable`.
- `mem_src_sel` output 1: to `dmem.src_sel`; constant 0 (scalar port).
- `mem_w_data` output 16: to `dmem.w_data_a`.
- `mem_q` input 16: from `dmem.q_a`.

## Operation
FSM states and transitions:
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch `req_we`, `req_addr`, `req_wdata`, then go to WRITE (store) or READ (load).
- WRITE: one lane per cycle, lane counter 0..15. `mem_addr = base + lane`, `mem_w_data` = latched lane, `mem_w_enable`=1. After lane 15, go to DONE.
- READ: one lane per cycle, 0..15. `mem_addr = base + lane`, `mem_w_enable`=0. After lane 15, go to DRAIN.
- DRAIN: waits `RD_LAT` cycles for outstanding data, then goes to DONE.
- DONE: `resp_valid`=1. It holds until `resp_ready`; on the handshake, go to IDLE.

Capture and address rules:
- A capture pipeline delays (valid, lane index) by `RD_LAT` cycles. When the delayed valid is set, write `mem_q` into lane `idx` of `resp_rdata`.
- Address arithmetic is modulo 2^32: `base + lane` wraps silently, with no error. For example, `0xFFFF_FFFF + 1 = 0`. `dmem` truncates the address further on its side.
- `resp_rdata`:
  - Cleared to 0 on acceptance of each request.
  - For stores it stays 0.
  - Holds its value after the DONE handshake until the next acceptance.
- Outside WRITE and READ: `mem_addr`=0, `mem_w_enable`=0, `mem_w_data`=0.

Boundary conditions:
- `req_valid` while not in IDLE is ignored; `req_ready`=0 outside IDLE.
- `req_ready` is 0 in DONE, so a new request is accepted at the earliest one cycle after the response handshake.
- `resp_ready` high before DONE has no effect.
- `rst_n` low mid-operation aborts immediately: no further writes are issued and the FSM returns to IDLE. Lanes already written stay in memory.
- Changes to `req_*` inputs after acceptance do not affect the operation in flight.

## Timing
Reset values (`rst_n`=0): state IDLE, `req_ready`=1, `busy`=0, `resp_valid`=0, `resp_rdata`=0, `mem_addr`=0, `mem_w_enable`=0, `mem_w_data`=0, `mem_src_sel`=0, capture pipeline cleared.

Store, accepted at edge T:
- Lanes are issued in cycles T+1..T+16.
- `resp_valid` is high from T+17.
- Minimum occupancy: 18 cycles, when `resp_ready` is already high.

Load, accepted at edge T:
- Addresses are issued in T+1..T+16.
- Lane i is captured at the end of cycle T+1+i+`RD_LAT`.
- `resp_valid` is high from T+17+`RD_LAT`; with `RD_LAT`=1 that is T+18.

All outputs are registered or decoded from state only. There is no combinational path from `req_*` or `resp_ready` to outputs, except `req_ready`, which is decoded from state.

## Test plan
- Reset check: hold `rst_n` low, then release. Require `req_ready`=1, `busy`=0, and all memory outputs 0 for 5 idle cycles.
- Store: base 0x100, lane i data = 0xA000+i. Require 16 consecutive writes to 0x100..0x10F with matching data, then `resp_valid` exactly 17 cycles after acceptance and `resp_rdata`=0.
- Load-back: load base 0x100 against a `dmem` model with `RD_LAT`=1. Require `resp_rdata` lane i = 0xA000+i and `resp_valid` 18 cycles after acceptance.
- Backpressure and busy: keep `resp_ready`=0 for 10 cycles in DONE. `resp_valid` must stay high and `resp_rdata` stable. `req_valid` pulsed during WRITE and DONE must not be accepted.
- Wrap: store with base 0xFFFF_FFF8. Require lanes 8..15 written to addresses 0x0..0x7.
- Abort: assert `rst_n` low in the cycle lane 5 is written. Require no write to base+6 or later, no `resp_valid`, and `req_ready`=1 after release. A following load returns new data for lanes 0..5 and old data for lanes 6..15.
